adc_swv_framer: RTL
===================

# adc_swv_framer

Sits between `adcOKInterface` and `BioEE_sdram_fifo` on the ADC data path. Decimates raw ADC samples by boxcar averaging of 2^AVG_LOG2 samples and inserts a sequence-numbered marker word on every SWV step (the `dac2SWVSetTrigger` strobe). This lets the host align each current reading to its DAC potential step. A small show-ahead output FIFO absorbs short write stalls, and an overflow is reported instead of silently corrupting the stream.

## Interface
Parameters:
- AVG_LOG2, default 2: samples averaged per data word = 2^AVG_LOG2 (legal range 0..4).
- FIFO_LOG2, default 2: output FIFO depth = 2^FIFO_LOG2 words.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  framing enable; low = accumulator cleared, din_valid and mark ignored.
- din  in  16  ADC sample; only din[14:0] used; din[15] ignored.
- din_valid  in  1  one-cycle strobe, din valid.
- mark  in  1  one-cycle SWV step strobe.
- dout  out  16  FIFO head word.
- dout_valid  out  1  FIFO non-empty.
- dout_ready  in  1  consumer accepts dout this cycle.
- overflow  out  1  sticky; set on any dropped word; cleared only by rst.
- drop_count  out  8  dropped words, saturating at 255.
- seq  out  8  sequence number the next marker will carry.

## Operation
- Word formats:
  - Data word = {1'b0, avg[14:0]}.
  - Marker word = {1'b1, 7'b0, seq[7:0]}.
  - The host separates the two by bit 15.
- Accumulator: unsigned sum, 15+AVG_LOG2 bits, plus a sample counter of AVG_LOG2+1 bits.
- din_valid with enable high: sum += din[14:0], counter++.
- When a sample brings the counter to 2^AVG_LOG2:
  - Push sum >> AVG_LOG2 (truncating) as a data word.
  - Clear sum and counter in the same cycle.
- mark with enable high:
  - Discard any partial window (sum and counter cleared, nothing pushed).
  - Push a marker word carrying the current seq.
  - seq increments, wrapping 255 -> 0.
- mark and din_valid in the same cycle: the marker is pushed, and that sample becomes the first sample of the new window (counter = 1, sum = din). At most one push per cycle by construction.
- AVG_LOG2 = 0: every sample is pushed directly as a data word. If mark coincides, the marker wins and the sample is dropped; it is not counted in drop_count.
- enable low: sum and counter are held at 0. seq, FIFO contents and output draining are unaffected.
- FIFO (show-ahead):
  - Pop occurs when dout_valid & dout_ready.
  - A push is accepted if occupancy − pop < depth, so push and pop when full in the same cycle are both accepted.
  - Otherwise the pushed word is dropped, overflow is set, and drop_count increments (saturating).
- Order is preserved; no word is ever modified after being pushed.

## Timing
- Reset values: dout = 0, dout_valid = 0, overflow = 0, drop_count = 0, seq = 0, FIFO empty, accumulator 0.
- Latency: a push in cycle N gives dout_valid = 1 with that word in cycle N+1 if the FIFO was empty. Otherwise the word appears when it reaches the head.
- seq, overflow and drop_count update at the edge that ends the push cycle.
- rst mid-window or with the FIFO non-empty: all state returns to reset values at the next edge, and pending words are lost.
- dout_ready has no combinational path to any input. dout and dout_valid are combinational from FIFO registers only.

## Test plan
- Averaging: AVG_LOG2 = 2, dout_ready = 1, samples 100, 200, 300, 400 -> a single word 0x00FA, dout_valid one cycle after the 4th sample. Then four samples of 0x7FFF -> 0x7FFF, with no sum wrap.
- Markers: two mark pulses, three cycles apart, after reset -> 0x8000 then 0x8001, seq = 2. 256 marks -> seq wraps, and the 257th marker is 0x8000.
- Partial flush: three samples, then mark -> only 0x8000 output. The next 4 samples of 8 -> 0x0008.
- Coincidence: mark together with a sample of 40, then samples 40, 40, 40 -> 0x8000 followed by 0x0028.
- Backpressure/overflow: dout_ready = 0, generate 6 markers -> 4 stored (0x8000..0x8003), overflow = 1, drop_count = 2, seq = 6. Raise dout_ready -> exactly those 4 words drain in order. Full FIFO with a push and pop in the same cycle -> no drop.
- Reset/enable: rst asserted after 2 samples with 3 words queued -> next cycle all outputs at reset values. enable low while pulsing mark and din_valid -> no words pushed and seq unchanged.

Source files
------------

// File: rtl/adc_swv_framer.sv
// ADC sample decimator and SWV step marker framer with a show-ahead output FIFO.
// Data words carry bit 15 = 0 and markers carry bit 15 = 1, so the host can tell them apart.
module adc_swv_framer #(
  parameter int AVG_LOG2  = 2,
  parameter int FIFO_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] din,
  input  logic        din_valid,
  input  logic        mark,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic [7:0]  seq
);

  localparam int SUM_W = 15 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1 << AVG_LOG2);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_V = (FIFO_LOG2 + 1)'(DEPTH);

  logic [SUM_W-1:0]   sumQ, sumD, sumAdd;
  logic [CNT_W-1:0]   cntQ, cntD, cntAdd;
  logic [7:0]         seqQ, dropQ;
  logic               pushEn, markPush, pop, accept;
  logic [15:0]        pushWord;
  logic [15:0]        mem [DEPTH];
  logic [FIFO_LOG2-1:0] wrPtr, rdPtr;
  logic [FIFO_LOG2:0]   count;
  logic               unusedDin;

  assign unusedDin = din[15];

  // A mark discards the partial window; a coincident sample opens the next one,
  // unless a window is a single sample, in which case the marker wins outright.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    sumD     = sumQ;
    cntD     = cntQ;
    pushEn   = 1'b0;
    markPush = 1'b0;
    pushWord = '0;
    sumAdd   = sumQ + SUM_W'(din[14:0]);
    cntAdd   = cntQ + CNT_W'(1);
    if (!enable) begin
      sumD = '0;
      cntD = '0;
    end else if (mark) begin
      pushEn   = 1'b1;
      markPush = 1'b1;
      pushWord = {8'h80, seqQ};
      if (din_valid && AVG_LOG2 != 0) begin
        sumD = SUM_W'(din[14:0]);
        cntD = CNT_W'(1);
      end else begin
        sumD = '0;
        cntD = '0;
      end
    end else if (din_valid) begin
      if (cntAdd == WIN_LEN) begin
        // Top 15 bits of the full-width sum are exactly sum >> AVG_LOG2.
        pushEn   = 1'b1;
        pushWord = {1'b0, sumAdd[SUM_W-1 -: 15]};
        sumD     = '0;
        cntD     = '0;
      end else begin
        sumD = sumAdd;
        cntD = cntAdd;
      end
    end
  end

  assign dout_valid = (count != '0);
  assign dout       = dout_valid ? mem[rdPtr] : '0;
  assign pop        = dout_valid & dout_ready;
  // Space freed by a same-cycle pop is usable, so a full FIFO can push and pop together.
  assign accept     = pushEn && ((count - (FIFO_LOG2 + 1)'(pop)) < DEPTH_V);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      sumQ     <= '0;
      cntQ     <= '0;
      seqQ     <= '0;
      dropQ    <= '0;
      overflow <= 1'b0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
    end else begin
      sumQ  <= sumD;
      cntQ  <= cntD;
      seqQ  <= seqQ + 8'(markPush);
      if (pop)    rdPtr <= rdPtr + 1'b1;
      if (accept) wrPtr <= wrPtr + 1'b1;
      count <= count + (FIFO_LOG2 + 1)'(accept) - (FIFO_LOG2 + 1)'(pop);
      if (pushEn && !accept) begin
        overflow <= 1'b1;
        if (dropQ != 8'hFF) dropQ <= dropQ + 8'd1;
      end
    end
  end

  // NOTE: storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wrPtr] <= pushWord;
  end

  assign drop_count = dropQ;
  assign seq        = seqQ;

endmodule
